vec_in_buff: RTL and testbench

VEC_IN_BUFF -- requirements
Module: vec_in_buff

---
 rtl/vec_in_buff.sv | 115 +++++++++++
 tb/tb_vec_in_buff.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_in_buff.sv
// Serial vector loader: a length byte followed by that many data bytes is
// assembled into a parallel vector and published with a one-cycle done pulse.
module vec_in_buff #(
  parameter int BITS = 8,
  parameter int N    = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [BITS-1:0] in,
  input  logic            in_valid,
  output logic [BITS-1:0] out [N-1:0],
  output logic [BITS-1:0] out_len,
  output logic            done,
  output logic            busy,
  output logic            err,
  output logic [1:0]      dbg_state
);

  localparam int IW = $clog2(N) + 1;
  localparam int AW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LEN  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  // Handshake: a byte on `in` is consumed on every rising edge where in_valid
  // is high and the block is in LEN or DATA; there is no backpressure, and
  // start in the same cycle wins so that byte is discarded.

  state_t          state_q, state_d;
  logic [IW-1:0]   index;
  logic [IW-1:0]   len_q;
  logic [BITS-1:0] vbuf [N-1:0];
  logic            len_zero;
  logic            len_over;
  logic            last_byte;

  assign len_zero  = (in == '0);
  assign len_over  = (32'(in) > 32'(N));
  assign last_byte = ((index + IW'(1)) == len_q);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: state_d = IDLE;
      LEN:  if (in_valid) state_d = len_zero ? DONE : DATA;
      DATA: if (in_valid && last_byte) state_d = DONE;
      DONE: state_d = IDLE;
    endcase
    if (start) state_d = LEN;
  end

  assign done      = (state_q == DONE);
  assign busy      = (state_q == LEN) || (state_q == DATA);
  assign dbg_state = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      index   <= '0;
      len_q   <= '0;
      err     <= 1'b0;
      out_len <= '0;
      for (int i = 0; i < N; i++) begin
        vbuf[i] <= '0;
        out[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      if (start) begin
        index <= '0;
        len_q <= '0;
        err   <= 1'b0;
        for (int i = 0; i < N; i++) vbuf[i] <= '0;
      end else begin
        unique case (state_q)
          LEN: begin
            if (in_valid) begin
              if (len_over) begin
                len_q <= IW'(N);
                err   <= 1'b1;
              end else begin
                len_q <= IW'(in);
              end
              // Empty frame: publish the (already cleared) buffer right away.
              if (len_zero) begin
                out_len <= '0;
                for (int i = 0; i < N; i++) out[i] <= vbuf[i];
              end
            end
          end
          DATA: begin
            if (in_valid) begin
              vbuf[index[AW-1:0]] <= in;
              if (last_byte) begin
                // Publish with the final byte merged so out is valid while done is high.
                out_len <= BITS'(len_q);
                for (int i = 0; i < N; i++)
                  out[i] <= (AW'(i) == index[AW-1:0]) ? in : vbuf[i];
              end else begin
                index <= index + IW'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vec_in_buff.sv
// Bench for vec_in_buff: frames are driven byte by byte, the expected vector is
// queued when the length byte goes out and checked on the done cycle.
module tb_vec_in_buff;

  localparam int BITS = 8;
  localparam int N    = 64;
  localparam int W    = N * BITS + BITS;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [BITS-1:0] in;
  logic            in_valid;
  logic [BITS-1:0] out [N-1:0];
  logic [BITS-1:0] out_len;
  logic            done;
  logic            busy;
  logic            err;
  logic [1:0]      dbg_state;

  logic [W-1:0]    exp_q [$];
  logic [W-1:0]    exp;
  logic [W-1:0]    last_exp;
  logic [7:0]      data_tbl [0:255];
  int              passed = 0;
  int              total = 0;
  int              done_cnt = 0;

  vec_in_buff #(.BITS(BITS), .N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .in(in), .in_valid(in_valid),
    .out(out), .out_len(out_len), .done(done), .busy(busy), .err(err),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  // Reference: length clamped to N, data bytes in order, zero fill above.
  function automatic logic [W-1:0] model_frame(input int len_b);
    logic [W-1:0] v;
    int l;
    l = (len_b > N) ? N : len_b;
    v = '0;
    for (int i = 0; i < l; i++) v[BITS + i*BITS +: BITS] = data_tbl[i];
    v[BITS-1:0] = BITS'(l);
    return v;
  endfunction

  function automatic logic [W-1:0] pack_dut();
    logic [W-1:0] v;
    v[BITS-1:0] = out_len;
    for (int i = 0; i < N; i++) v[BITS + i*BITS +: BITS] = out[i];
    return v;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    in = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in = 8'($urandom);
  endtask

  task automatic idle_cycle();
    in = 8'($urandom); in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_frame(input int len_b, input int ndata, input int gap_max);
    send_byte(8'(len_b));
    exp_q.push_back(model_frame(len_b));
    for (int i = 0; i < ndata; i++) begin
      repeat ($urandom_range(0, gap_max)) idle_cycle();
      send_byte(data_tbl[i]);
    end
  endtask

  task automatic test_reset();
    total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    total++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else passed++;
    total++; if (dbg_state !== 2'd0) $display("FAIL reset_state: got %0d want 0", dbg_state); else passed++;
    total++; if (pack_dut() !== '0) $display("FAIL reset_out: got %h want 0", pack_dut()); else passed++;
  endtask

  task automatic test_basic();
    int c0;
    c0 = done_cnt;
    pulse_start();
    total++; if (busy !== 1'b1) $display("FAIL basic_busy: got %b want 1", busy); else passed++;
    data_tbl[0] = 8'hA1; data_tbl[1] = 8'hB2; data_tbl[2] = 8'hC3;
    send_frame(3, 3, 0);
    total++; if (done !== 1'b1) $display("FAIL basic_done: got %b want 1", done); else passed++;
    total++;
    if (exp_q.size() > 0) exp = exp_q.pop_front(); else exp = 'x;
    if (pack_dut() !== exp) $display("FAIL basic_out: got %h want %h", pack_dut(), exp); else passed++;
    total++; if (err !== 1'b0) $display("FAIL basic_err: got %b want 0", err); else passed++;
    idle_cycle();
    total++; if (done !== 1'b0) $display("FAIL basic_done_clear: got %b want 0", done); else passed++;
    total++; if (done_cnt - c0 !== 1) $display("FAIL basic_pulses: got %0d want 1", done_cnt - c0); else passed++;
  endtask

  task automatic test_zero_len();
    pulse_start();
    send_frame(0, 0, 0);
    total++; if (done !== 1'b1) $display("FAIL zero_done: got %b want 1", done); else passed++;
    total++;
    if (exp_q.size() > 0) exp = exp_q.pop_front(); else exp = 'x;
    if (pack_dut() !== exp) $display("FAIL zero_out: got %h want %h", pack_dut(), exp); else passed++;
    idle_cycle();
  endtask

  task automatic test_overflow();
    int c0;
    c0 = done_cnt;
    for (int i = 0; i < N; i++) data_tbl[i] = 8'(i);
    pulse_start();
    send_frame(200, N, 0);
    total++; if (done !== 1'b1) $display("FAIL ovf_done: got %b want 1", done); else passed++;
    total++; if (err !== 1'b1) $display("FAIL ovf_err: got %b want 1", err); else passed++;
    total++;
    if (exp_q.size() > 0) exp = exp_q.pop_front(); else exp = 'x;
    if (pack_dut() !== exp) $display("FAIL ovf_out: got %h want %h", pack_dut(), exp); else passed++;
    last_exp = exp;
    send_byte(8'hEE);
    idle_cycle();
    total++; if (pack_dut() !== last_exp) $display("FAIL ovf_extra_byte: got %h want %h", pack_dut(), last_exp); else passed++;
    total++; if (err !== 1'b1) $display("FAIL ovf_err_sticky: got %b want 1", err); else passed++;
    total++; if (done_cnt - c0 !== 1) $display("FAIL ovf_pulses: got %0d want 1", done_cnt - c0); else passed++;
  endtask

  task automatic test_abort();
    int c0;
    c0 = done_cnt;
    pulse_start();
    total++; if (err !== 1'b0) $display("FAIL abort_err_clear: got %b want 0", err); else passed++;
    send_byte(8'd4); send_byte(8'h11); send_byte(8'h22);
    total++; if (pack_dut() !== last_exp) $display("FAIL abort_out_hold: got %h want %h", pack_dut(), last_exp); else passed++;
    pulse_start();
    data_tbl[0] = 8'h55;
    send_frame(1, 1, 0);
    total++; if (done !== 1'b1) $display("FAIL abort_done: got %b want 1", done); else passed++;
    total++;
    if (exp_q.size() > 0) exp = exp_q.pop_front(); else exp = 'x;
    if (pack_dut() !== exp) $display("FAIL abort_out: got %h want %h", pack_dut(), exp); else passed++;
    idle_cycle();
    total++; if (done_cnt - c0 !== 1) $display("FAIL abort_pulses: got %0d want 1", done_cnt - c0); else passed++;
  endtask

  task automatic test_gapped();
    pulse_start();
    data_tbl[0] = 8'hA1; data_tbl[1] = 8'hB2; data_tbl[2] = 8'hC3;
    send_byte(8'd3);
    exp_q.push_back(model_frame(3));
    send_byte(8'hA1); idle_cycle(); idle_cycle();
    send_byte(8'hB2); idle_cycle();
    total++; if (done !== 1'b0) $display("FAIL gap_early_done: got %b want 0", done); else passed++;
    send_byte(8'hC3);
    total++; if (done !== 1'b1) $display("FAIL gap_done: got %b want 1", done); else passed++;
    total++;
    if (exp_q.size() > 0) exp = exp_q.pop_front(); else exp = 'x;
    if (pack_dut() !== exp) $display("FAIL gap_out: got %h want %h", pack_dut(), exp); else passed++;
    idle_cycle();
  endtask

  task automatic test_rst_mid();
    int c0;
    int len_b;
    c0 = done_cnt;
    pulse_start();
    send_byte(8'd5); send_byte(8'h01); send_byte(8'h02);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle_cycle();
    total++; if (done_cnt !== c0) $display("FAIL rst_no_done: got %0d want %0d", done_cnt, c0); else passed++;
    total++; if (pack_dut() !== '0) $display("FAIL rst_out: got %h want 0", pack_dut()); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passed++;
    len_b = $urandom_range(1, N);
    for (int i = 0; i < len_b; i++) data_tbl[i] = 8'($urandom);
    pulse_start();
    send_frame(len_b, len_b, 1);
    total++; if (done !== 1'b1) $display("FAIL rst_after_done: got %b want 1", done); else passed++;
    total++;
    if (exp_q.size() > 0) exp = exp_q.pop_front(); else exp = 'x;
    if (pack_dut() !== exp) $display("FAIL rst_after_out: got %h want %h", pack_dut(), exp); else passed++;
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    int c0;
    c0 = done_cnt;
    data_tbl[0] = 8'h11; data_tbl[1] = 8'h22;
    pulse_start();
    send_frame(2, 2, 0);
    start = 1'b1;
    total++; if (done !== 1'b1) $display("FAIL b2b_done1: got %b want 1", done); else passed++;
    total++;
    if (exp_q.size() > 0) exp = exp_q.pop_front(); else exp = 'x;
    if (pack_dut() !== exp) $display("FAIL b2b_out1: got %h want %h", pack_dut(), exp); else passed++;
    @(posedge clk); #1;
    start = 1'b0;
    total++; if (dbg_state !== 2'd1) $display("FAIL b2b_len_state: got %0d want 1", dbg_state); else passed++;
    data_tbl[0] = 8'h33;
    send_frame(1, 1, 0);
    total++; if (done !== 1'b1) $display("FAIL b2b_done2: got %b want 1", done); else passed++;
    total++;
    if (exp_q.size() > 0) exp = exp_q.pop_front(); else exp = 'x;
    if (pack_dut() !== exp) $display("FAIL b2b_out2: got %h want %h", pack_dut(), exp); else passed++;
    last_exp = exp;
    idle_cycle();
    send_byte(8'h99); send_byte(8'h03); send_byte(8'h7F);
    total++; if (busy !== 1'b0 || err !== 1'b0) $display("FAIL idle_drop_flags: got busy=%b err=%b want 0 0", busy, err); else passed++;
    total++; if (pack_dut() !== last_exp) $display("FAIL idle_drop_out: got %h want %h", pack_dut(), last_exp); else passed++;
    idle_cycle();
    total++; if (done_cnt - c0 !== 2) $display("FAIL b2b_pulses: got %0d want 2", done_cnt - c0); else passed++;
  endtask

  task automatic test_random();
    int len_b;
    int nd;
    for (int f = 0; f < 5; f++) begin
      len_b = $urandom_range(1, N + 40);
      nd = (len_b > N) ? N : len_b;
      for (int i = 0; i < nd; i++) data_tbl[i] = 8'($urandom);
      pulse_start();
      send_frame(len_b, nd, 2);
      total++; if (done !== 1'b1) $display("FAIL rand_done f%0d: got %b want 1", f, done); else passed++;
      total++; if (err !== (len_b > N)) $display("FAIL rand_err f%0d: got %b want %b", f, err, len_b > N); else passed++;
      total++;
      if (exp_q.size() > 0) exp = exp_q.pop_front(); else exp = 'x;
      if (pack_dut() !== exp) $display("FAIL rand_out f%0d: got %h want %h", f, pack_dut(), exp); else passed++;
      repeat ($urandom_range(0, 3)) idle_cycle();
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; in = 8'h07; in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    test_reset();
    test_basic();
    test_zero_len();
    test_overflow();
    test_abort();
    test_gapped();
    test_rst_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
